// File: rtl/vdp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdp_pkg
// Description : Shared encodings for the TMS9918-style CPU port controller:
//               display-mode codes, access-sequencer states, VDP register
//               indices, register bit positions, status bit positions and
//               table-base shift amounts.
// Revision    : 1.0 - initial release
// ============================================================================
package vdp_pkg;

   // Display modes as presented on the mode output
   typedef enum logic [1:0] {
      MODE_TEXT  = 2'd0,
      MODE_GFX1  = 2'd1,
      MODE_GFX2  = 2'd2,
      MODE_MULTI = 2'd3
   } vdp_mode_e;

   // VRAM access sequencer
   typedef enum logic [1:0] {
      ACC_IDLE = 2'd0,
      ACC_RD   = 2'd1,
      ACC_CAP  = 2'd2,
      ACC_WR   = 2'd3
   } acc_state_e;

   // Register indices
   localparam int REG_R0 = 0;
   localparam int REG_R1 = 1;
   localparam int REG_R2 = 2;
   localparam int REG_R3 = 3;
   localparam int REG_R4 = 4;
   localparam int REG_R5 = 5;
   localparam int REG_R6 = 6;
   localparam int REG_R7 = 7;

   // Bit positions inside R0 / R1
   localparam int R0_M3    = 1;
   localparam int R1_BLANK = 6;
   localparam int R1_IE    = 5;
   localparam int R1_M1    = 4;
   localparam int R1_M2    = 3;
   localparam int R1_SIZE  = 1;
   localparam int R1_MAG   = 0;

   // Status word bit positions; bits 4:0 carry the fifth-sprite number
   localparam int ST_F  = 7;
   localparam int ST_5S = 6;
   localparam int ST_C  = 5;

   // Table-base generation
   localparam int TBL_W       = 14;
   localparam int NAME_SHIFT  = 10;
   localparam int COLOR_SHIFT = 6;
   localparam int FONT_SHIFT  = 11;
   localparam int SATTR_SHIFT = 7;
   localparam int SPAT_SHIFT  = 11;

   // M1 outranks M3, which outranks M2; no mode bit selects graphics I
   function automatic vdp_mode_e decode_mode(input logic [7:0] r0,
                                             input logic [7:0] r1);
      vdp_mode_e m;
      if (r1[R1_M1])      m = MODE_TEXT;
      else if (r0[R0_M3]) m = MODE_GFX2;
      else if (r1[R1_M2]) m = MODE_MULTI;
      else                m = MODE_GFX1;
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vdp_status_reg.sv
`default_nettype none
// ============================================================================
// Module      : vdp_status_reg
// Description : VDP status register. Holds the frame flag (F), the fifth
//               sprite flag (5S) with its latched sprite number, and the
//               collision flag (C). All three flags clear on a status read;
//               a set event in the same cycle as the read takes priority.
//               Drives the active-low interrupt line.
// Ports       : clk, reset       - clock, async active-high reset
//               frame_tick       - vertical retrace pulse, sets F
//               coll_in          - sprite collision, sets C
//               fifth_in         - too-many-sprites, sets 5S
//               fifth_num[4:0]   - sprite number, latched while 5S = 0
//               status_rd        - accepted status read (clears flags)
//               int_en           - interrupt enable (R1 IE bit)
//               status[7:0]      - {F, 5S, C, fifth number}
//               n_int            - active-low interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_status_reg
   import vdp_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       coll_in,
   input  logic       fifth_in,
   input  logic [4:0] fifth_num,
   input  logic       status_rd,
   input  logic       int_en,
   output logic [7:0] status,
   output logic       n_int
);

   logic       f_q,    f_d;
   logic       c_q,    c_d;
   logic       s5_q,   s5_d;
   logic [4:0] fnum_q, fnum_d;

   always_comb begin
      // Set terms are ORed after the clear so a coincident event survives
      f_d    = frame_tick | (f_q  & ~status_rd);
      c_d    = coll_in    | (c_q  & ~status_rd);
      s5_d   = fifth_in   | (s5_q & ~status_rd);
      // Only the first offending sprite of a frame is recorded
      fnum_d = (fifth_in && !s5_q) ? fifth_num : fnum_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         f_q    <= 1'b0;
         c_q    <= 1'b0;
         s5_q   <= 1'b0;
         fnum_q <= 5'd0;
      end else begin
         f_q    <= f_d;
         c_q    <= c_d;
         s5_q   <= s5_d;
         fnum_q <= fnum_d;
      end
   end

   always_comb begin
      status        = 8'd0;
      status[ST_F]  = f_q;
      status[ST_5S] = s5_q;
      status[ST_C]  = c_q;
      status[4:0]   = fnum_q;
   end

   assign n_int = ~(f_q & int_en);

endmodule
`default_nettype wire

// File: rtl/vdp_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vdp_port_ctrl
// Description : CPU-facing controller of the TMS9918-style video block.
//               Decodes the data (a0 = 0) and control/status (a0 = 1) ports,
//               holds the two-byte control latch, the VRAM address counter
//               and read-ahead buffer, sequences VRAM reads/writes, holds
//               registers R0-R7 and drives the video configuration outputs.
// Ports       : clk, reset             - clock, async active-high reset
//               io_wr/io_rd/io_a0/io_din/io_dout - CPU port interface
//               busy                   - VRAM access in flight
//               vram_addr/wdata/we/re/rdata      - VRAM CPU-side port
//               frame_tick/coll_in/fifth_in/fifth_num - renderer events
//               mode, video_on, sprite_large, sprite_enlarged,
//               vert_retrace_int, *_addr, text_color, back_color - config
//               n_int                  - active-low interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_port_ctrl
   import vdp_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int NREGS  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              io_wr,
   input  logic              io_rd,
   input  logic              io_a0,
   input  logic [7:0]        io_din,
   output logic [7:0]        io_dout,
   output logic              busy,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [7:0]        vram_wdata,
   output logic              vram_we,
   output logic              vram_re,
   input  logic [7:0]        vram_rdata,
   input  logic              frame_tick,
   input  logic              coll_in,
   input  logic              fifth_in,
   input  logic [4:0]        fifth_num,
   output logic [1:0]        mode,
   output logic              video_on,
   output logic              sprite_large,
   output logic              sprite_enlarged,
   output logic              vert_retrace_int,
   output logic [TBL_W-1:0]  name_table_addr,
   output logic [TBL_W-1:0]  color_table_addr,
   output logic [TBL_W-1:0]  font_addr,
   output logic [TBL_W-1:0]  sprite_attr_addr,
   output logic [TBL_W-1:0]  sprite_pattern_table_addr,
   output logic [3:0]        text_color,
   output logic [3:0]        back_color,
   output logic              n_int
);

   acc_state_e        state_q, state_d;
   logic              phase_q, phase_d;
   logic [7:0]        latch_q, latch_d;
   logic [7:0]        buf_q,   buf_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [ADDR_W-1:0] vaddr_q, vaddr_d;
   logic              we_q,    we_d;
   logic              re_q,    re_d;
   logic              busy_q,  busy_d;
   logic [7:0]        regs_q [NREGS];
   logic [7:0]        regs_d [NREGS];

   logic              status_rd;
   logic [7:0]        status_word;

   // ------------------------------------------------------------------------
   // Next-state logic. Strobes are only decoded in ACC_IDLE, which is the
   // only state with busy low, so anything arriving mid-access is dropped.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      latch_d   = latch_q;
      buf_d     = buf_q;
      wdata_d   = wdata_q;
      addr_d    = addr_q;
      vaddr_d   = vaddr_q;
      we_d      = 1'b0;
      re_d      = 1'b0;
      busy_d    = busy_q;
      regs_d    = regs_q;
      status_rd = 1'b0;

      case (state_q)
         ACC_RD: begin
            state_d = ACC_CAP;
            busy_d  = 1'b1;
         end
         ACC_CAP: begin
            // Read data is valid one cycle after vram_re
            buf_d   = vram_rdata;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ACC_IDLE;
            busy_d  = 1'b0;
         end
         ACC_WR: begin
            state_d = ACC_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            if (io_wr) begin
               if (io_a0) begin
                  if (!phase_q) begin
                     latch_d = io_din;
                     phase_d = 1'b1;
                  end else begin
                     phase_d = 1'b0;
                     if (io_din[7]) begin
                        if (int'(io_din[2:0]) < NREGS) begin
                           regs_d[io_din[2:0]] = latch_q;
                        end
                     end else begin
                        addr_d = ADDR_W'({io_din[5:0], latch_q});
                        // bit 6 clear marks a read setup: fill the buffer now
                        if (!io_din[6]) begin
                           vaddr_d = addr_d;
                           re_d    = 1'b1;
                           busy_d  = 1'b1;
                           state_d = ACC_RD;
                        end
                     end
                  end
               end else begin
                  // Data write also refreshes the read buffer
                  phase_d = 1'b0;
                  wdata_d = io_din;
                  buf_d   = io_din;
                  vaddr_d = addr_q;
                  addr_d  = addr_q + ADDR_W'(1);
                  we_d    = 1'b1;
                  busy_d  = 1'b1;
                  state_d = ACC_WR;
               end
            end else if (io_rd) begin
               phase_d = 1'b0;
               if (io_a0) begin
                  status_rd = 1'b1;
               end else begin
                  // io_dout already presents the buffer; refill it behind
                  vaddr_d = addr_q;
                  re_d    = 1'b1;
                  busy_d  = 1'b1;
                  state_d = ACC_RD;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ACC_IDLE;
         phase_q <= 1'b0;
         latch_q <= 8'd0;
         buf_q   <= 8'd0;
         wdata_q <= 8'd0;
         addr_q  <= '0;
         vaddr_q <= '0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         busy_q  <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= 8'd0;
         end
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         latch_q <= latch_d;
         buf_q   <= buf_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         vaddr_q <= vaddr_d;
         we_q    <= we_d;
         re_q    <= re_d;
         busy_q  <= busy_d;
         regs_q  <= regs_d;
      end
   end

   // ------------------------------------------------------------------------
   // Status register and interrupt
   // ------------------------------------------------------------------------
   vdp_status_reg u_status (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .coll_in    (coll_in),
      .fifth_in   (fifth_in),
      .fifth_num  (fifth_num),
      .status_rd  (status_rd),
      .int_en     (regs_q[REG_R1][R1_IE]),
      .status     (status_word),
      .n_int      (n_int)
   );

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign io_dout    = io_a0 ? status_word : buf_q;
   assign busy       = busy_q;
   assign vram_addr  = vaddr_q;
   assign vram_wdata = wdata_q;
   assign vram_we    = we_q;
   assign vram_re    = re_q;

   assign mode             = decode_mode(regs_q[REG_R0], regs_q[REG_R1]);
   assign video_on         = regs_q[REG_R1][R1_BLANK];
   assign sprite_large     = regs_q[REG_R1][R1_SIZE];
   assign sprite_enlarged  = regs_q[REG_R1][R1_MAG];
   assign vert_retrace_int = regs_q[REG_R1][R1_IE];

   assign name_table_addr           = TBL_W'(regs_q[REG_R2][3:0]) << NAME_SHIFT;
   assign color_table_addr          = TBL_W'(regs_q[REG_R3])      << COLOR_SHIFT;
   assign font_addr                 = TBL_W'(regs_q[REG_R4][2:0]) << FONT_SHIFT;
   assign sprite_attr_addr          = TBL_W'(regs_q[REG_R5][6:0]) << SATTR_SHIFT;
   assign sprite_pattern_table_addr = TBL_W'(regs_q[REG_R6][2:0]) << SPAT_SHIFT;

   assign text_color = regs_q[REG_R7][7:4];
   assign back_color = regs_q[REG_R7][3:0];

   // Register bits with no decoded function
   logic w_unused_reg_bits;
   assign w_unused_reg_bits = ^{regs_q[REG_R0], regs_q[REG_R1], regs_q[REG_R2],
                                regs_q[REG_R4], regs_q[REG_R5], regs_q[REG_R6]};

endmodule
`default_nettype wire

// File: tb/tb_vdp_port_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vdp_port_ctrl
// Description : Self-checking bench for vdp_port_ctrl. A VRAM model answers
//               the CPU-side port; a transaction-level reference model
//               predicts registers, address counter, buffer and flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vdp_port_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        io_wr, io_rd, io_a0;
   logic [7:0]  io_din;
   logic [7:0]  io_dout;
   logic        busy;
   logic [13:0] vram_addr;
   logic [7:0]  vram_wdata;
   logic        vram_we, vram_re;
   logic [7:0]  vram_rdata = 8'd0;
   logic        frame_tick, coll_in, fifth_in;
   logic [4:0]  fifth_num;
   logic [1:0]  mode;
   logic        video_on, sprite_large, sprite_enlarged, vert_retrace_int;
   logic [13:0] name_table_addr, color_table_addr, font_addr;
   logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
   logic [3:0]  text_color, back_color;
   logic        n_int;

   always #5 clk = ~clk;

   vdp_port_ctrl #(.ADDR_W(14), .NREGS(8)) dut (
      .clk(clk), .reset(reset),
      .io_wr(io_wr), .io_rd(io_rd), .io_a0(io_a0), .io_din(io_din), .io_dout(io_dout),
      .busy(busy),
      .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
      .vram_re(vram_re), .vram_rdata(vram_rdata),
      .frame_tick(frame_tick), .coll_in(coll_in), .fifth_in(fifth_in), .fifth_num(fifth_num),
      .mode(mode), .video_on(video_on), .sprite_large(sprite_large),
      .sprite_enlarged(sprite_enlarged), .vert_retrace_int(vert_retrace_int),
      .name_table_addr(name_table_addr), .color_table_addr(color_table_addr),
      .font_addr(font_addr), .sprite_attr_addr(sprite_attr_addr),
      .sprite_pattern_table_addr(sprite_pattern_table_addr),
      .text_color(text_color), .back_color(back_color), .n_int(n_int)
   );

   // ---------------- VRAM model and bus monitor ----------------
   logic [7:0] mem     [16384];
   logic [7:0] ref_mem [16384];
   int seen_we_a[$], seen_we_d[$], seen_re[$];
   int exp_we_a[$],  exp_we_d[$],  exp_re[$];

   always @(posedge clk) begin
      if (vram_we) mem[vram_addr] = vram_wdata;
      if (vram_re) vram_rdata <= mem[vram_addr];
   end

   always @(negedge clk) begin
      if (vram_we) begin
         seen_we_a.push_back(int'(vram_addr));
         seen_we_d.push_back(int'(vram_wdata));
      end
      if (vram_re) seen_re.push_back(int'(vram_addr));
   end

   // ---------------- reference model state ----------------
   logic [7:0] m_regs [8];
   bit         m_phase;
   logic [7:0] m_latch;
   int         m_addr;
   logic [7:0] m_buf;
   bit         m_F, m_C, m_5S;
   logic [4:0] m_fnum;

   int checks = 0;
   int errors = 0;
   logic [7:0] dv;
   logic       nv;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
      m_phase = 0; m_latch = 8'd0; m_addr = 0; m_buf = 8'd0;
      m_F = 0; m_C = 0; m_5S = 0; m_fnum = 5'd0;
      seen_we_a.delete(); seen_we_d.delete(); seen_re.delete();
      exp_we_a.delete();  exp_we_d.delete();  exp_re.delete();
   endtask

   function automatic logic [7:0] m_status();
      return {m_F, m_5S, m_C, m_fnum};
   endfunction

   function automatic int exp_mode();
      if (m_regs[1][4]) return 0;
      if (m_regs[0][1]) return 2;
      if (m_regs[1][3]) return 3;
      return 1;
   endfunction

   task automatic prefetch();
      exp_re.push_back(m_addr);
      m_buf  = ref_mem[m_addr];
      m_addr = (m_addr + 1) % 16384;
   endtask

   task automatic check_outputs();
      chk("mode", int'(mode), exp_mode());
      chk("video_on", int'(video_on), int'(m_regs[1][6]));
      chk("sprite_large", int'(sprite_large), int'(m_regs[1][1]));
      chk("sprite_enlarged", int'(sprite_enlarged), int'(m_regs[1][0]));
      chk("vert_retrace_int", int'(vert_retrace_int), int'(m_regs[1][5]));
      chk("name_tbl", int'(name_table_addr), (int'(m_regs[2]) % 16) * 1024);
      chk("color_tbl", int'(color_table_addr), int'(m_regs[3]) * 64);
      chk("font_tbl", int'(font_addr), (int'(m_regs[4]) % 8) * 2048);
      chk("sattr_tbl", int'(sprite_attr_addr), (int'(m_regs[5]) % 128) * 128);
      chk("spat_tbl", int'(sprite_pattern_table_addr), (int'(m_regs[6]) % 8) * 2048);
      chk("text_color", int'(text_color), int'(m_regs[7]) / 16);
      chk("back_color", int'(back_color), int'(m_regs[7]) % 16);
      chk("n_int", int'(n_int), (m_F && m_regs[1][5]) ? 0 : 1);
      chk("busy_idle", int'(busy), 0);
      chk("we_idle", int'(vram_we), 0);
      chk("re_idle", int'(vram_re), 0);
   endtask

   task automatic check_bus();
      chk("we_count", seen_we_a.size(), exp_we_a.size());
      while (seen_we_a.size() > 0 && exp_we_a.size() > 0) begin
         chk("we_addr", seen_we_a.pop_front(), exp_we_a.pop_front());
         chk("we_data", seen_we_d.pop_front(), exp_we_d.pop_front());
      end
      chk("re_count", seen_re.size(), exp_re.size());
      while (seen_re.size() > 0 && exp_re.size() > 0)
         chk("re_addr", seen_re.pop_front(), exp_re.pop_front());
      seen_we_a.delete(); seen_we_d.delete(); seen_re.delete();
      exp_we_a.delete();  exp_we_d.delete();  exp_re.delete();
   endtask

   // One CPU access, then idle so the next strobe lands 5 cycles later.
   // nn is n_int in the cycle right after the strobe.
   task automatic do_op(input bit wr, input bit a0, input logic [7:0] d, input bit ft,
                        output logic [7:0] dout, output logic nn);
      logic [7:0] exp_rd;
      exp_rd = a0 ? m_status() : m_buf;
      @(posedge clk); #1;
      chk("idle_before_strobe", int'(busy), 0);
      io_wr = wr; io_rd = !wr; io_a0 = a0; io_din = d; frame_tick = ft;
      #1 dout = io_dout;
      @(posedge clk); #1;
      io_wr = 0; io_rd = 0; frame_tick = 0;
      nn = n_int;
      repeat (3) @(posedge clk);
      #1;
      if (!wr) chk(a0 ? "status_rd" : "data_rd", int'(dout), int'(exp_rd));
      if (wr && a0) begin
         if (!m_phase) begin
            m_latch = d; m_phase = 1;
         end else begin
            m_phase = 0;
            if (d[7]) m_regs[int'(d[2:0])] = m_latch;
            else begin
               m_addr = int'(d & 8'h3F) * 256 + int'(m_latch);
               if (!d[6]) prefetch();
            end
         end
      end else if (wr) begin
         m_phase = 0;
         exp_we_a.push_back(m_addr); exp_we_d.push_back(int'(d));
         ref_mem[m_addr] = d;
         m_buf  = d;
         m_addr = (m_addr + 1) % 16384;
      end else if (a0) begin
         m_phase = 0;
         m_F = 0; m_C = 0; m_5S = 0;
      end else begin
         m_phase = 0;
         prefetch();
      end
      if (ft) m_F = 1;
      check_bus();
      check_outputs();
   endtask

   task automatic ctrl(input logic [7:0] d); do_op(1, 1, d, 0, dv, nv); endtask
   task automatic dwr(input logic [7:0] d);  do_op(1, 0, d, 0, dv, nv); endtask

   task automatic pulse(input bit ft, input bit co, input bit fi, input logic [4:0] num);
      @(posedge clk); #1;
      frame_tick = ft; coll_in = co; fifth_in = fi; fifth_num = num;
      @(posedge clk); #1;
      frame_tick = 0; coll_in = 0; fifth_in = 0;
      m_F = m_F | ft;
      m_C = m_C | co;
      if (fi && !m_5S) begin m_5S = 1; m_fnum = num; end
      check_outputs();
   endtask

   typedef struct { logic [2:0] idx; logic [7:0] val; int sel; int exp; } reg_vec_t;
   typedef struct { logic [7:0] r0; logic [7:0] r1; int exp; } mode_vec_t;
   reg_vec_t  rv[12];
   mode_vec_t mv[6];

   function automatic int pick(input int sel);
      case (sel)
         0: return int'(name_table_addr);
         1: return int'(color_table_addr);
         2: return int'(font_addr);
         3: return int'(sprite_attr_addr);
         4: return int'(sprite_pattern_table_addr);
         5: return int'(text_color);
         default: return int'(back_color);
      endcase
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic       nn;
      reset = 1; io_wr = 0; io_rd = 0; io_a0 = 0; io_din = 8'd0;
      frame_tick = 0; coll_in = 0; fifth_in = 0; fifth_num = 5'd0;
      for (int i = 0; i < 16384; i++) begin
         mem[i] = 8'($urandom);
         ref_mem[i] = mem[i];
      end
      rv[0]  = '{3'd2, 8'h0F, 0, 'h3C00};
      rv[1]  = '{3'd2, 8'hF6, 0, 'h1800};
      rv[2]  = '{3'd3, 8'hFF, 1, 'h3FC0};
      rv[3]  = '{3'd3, 8'h80, 1, 'h2000};
      rv[4]  = '{3'd4, 8'h03, 2, 'h1800};
      rv[5]  = '{3'd4, 8'hFF, 2, 'h3800};
      rv[6]  = '{3'd5, 8'h36, 3, 'h1B00};
      rv[7]  = '{3'd5, 8'hFF, 3, 'h3F80};
      rv[8]  = '{3'd6, 8'h07, 4, 'h3800};
      rv[9]  = '{3'd6, 8'h01, 4, 'h0800};
      rv[10] = '{3'd7, 8'hF4, 5, 'hF};
      rv[11] = '{3'd7, 8'h1E, 6, 'hE};
      mv[0] = '{8'h00, 8'h00, 1};
      mv[1] = '{8'h02, 8'h00, 2};
      mv[2] = '{8'h00, 8'h08, 3};
      mv[3] = '{8'h02, 8'h08, 2};
      mv[4] = '{8'h02, 8'h10, 0};
      mv[5] = '{8'h00, 8'h18, 0};

      // Reset state
      repeat (3) @(posedge clk); #1;
      chk("rst_mode", int'(mode), 1);
      chk("rst_video_on", int'(video_on), 0);
      chk("rst_n_int", int'(n_int), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_we", int'(vram_we), 0);
      chk("rst_re", int'(vram_re), 0);
      io_a0 = 0; #1 chk("rst_buf", int'(io_dout), 0);
      io_a0 = 1; #1 chk("rst_status", int'(io_dout), 0);
      io_a0 = 0;
      reset = 0;
      model_reset();

      // Register write R1 = 0xE0
      ctrl(8'hE0); ctrl(8'h81);
      chk("r1_video_on", int'(video_on), 1);
      chk("r1_vrint", int'(vert_retrace_int), 1);
      chk("r1_mode", int'(mode), 1);

      // Write setup at 0x1800 and two data writes
      ctrl(8'h00); ctrl(8'h58);
      dwr(8'hAA); chk("wr0_addr", int'(vram_addr), 'h1800);
      dwr(8'hBB); chk("wr1_addr", int'(vram_addr), 'h1801);
      do_op(0, 0, 8'h00, 0, d, nn);
      chk("rd_after_wr", int'(d), 'hBB);
      chk("prefetch_1802", int'(vram_addr), 'h1802);

      // Read setup at the top of VRAM, counter wraps
      ctrl(8'hFF); ctrl(8'h3F);
      chk("re_3fff", int'(vram_addr), 'h3FFF);
      do_op(0, 0, 8'h00, 0, d, nn);
      chk("rd_3fff_data", int'(d), int'(ref_mem[16383]));
      chk("prefetch_wrap", int'(vram_addr), 'h0000);

      // Interrupt and clear-on-read
      pulse(1, 0, 0, 5'd0);
      chk("int_asserted", int'(n_int), 0);
      do_op(0, 1, 8'h00, 0, d, nn);
      chk("status_F_set", int'(d[7]), 1);
      chk("n_int_after_rd", int'(nn), 1);
      do_op(0, 1, 8'h00, 1, d, nn);
      chk("coincide_next", int'(nn), 0);
      do_op(0, 1, 8'h00, 0, d, nn);
      chk("coincide_F_kept", int'(d[7]), 1);

      // Enabling IE while F is pending
      ctrl(8'hC0); ctrl(8'h81);
      pulse(1, 0, 0, 5'd0);
      chk("ie_off_no_int", int'(n_int), 1);
      ctrl(8'hE0); do_op(1, 1, 8'h81, 0, d, nn);
      chk("ie_on_next", int'(nn), 0);

      // Collision and fifth sprite; only the first number is latched
      pulse(0, 1, 1, 5'h13);
      pulse(0, 0, 1, 5'h05);
      do_op(0, 1, 8'h00, 0, d, nn);
      chk("status_5s_c_num", int'(d & 8'h7F), 'h73);

      // Phase reset by a status read
      ctrl(8'h12);
      do_op(0, 1, 8'h00, 0, d, nn);
      ctrl(8'h34); ctrl(8'h56);
      dwr(8'h77);
      chk("phase_reset_addr", int'(vram_addr), 'h1634);

      // Table-base vectors
      foreach (rv[i]) begin
         ctrl(rv[i].val); ctrl(8'h80 | 8'(rv[i].idx));
         chk("tbl_vec", pick(rv[i].sel), rv[i].exp);
      end

      // Mode priority vectors
      foreach (mv[i]) begin
         ctrl(mv[i].r0); ctrl(8'h80);
         ctrl(mv[i].r1); ctrl(8'h81);
         chk("mode_vec", int'(mode), mv[i].exp);
      end

      // Reset in the middle of a prefetch
      ctrl(8'h23); ctrl(8'h01);
      @(posedge clk); #1 io_rd = 1; io_a0 = 0;
      @(posedge clk); #1 io_rd = 0;
      reset = 1; #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_re", int'(vram_re), 0);
      chk("abort_buf", int'(io_dout), 0);
      repeat (2) @(posedge clk); #1 reset = 0;
      model_reset();
      check_outputs();

      // Randomized traffic
      for (int n = 0; n < 250; n++) begin
         case ($urandom_range(0, 6))
            0: begin ctrl(8'($urandom)); ctrl(8'h80 | 8'($urandom_range(0, 7))); end
            1: begin
               ctrl(8'($urandom));
               ctrl({1'b0, 1'($urandom_range(0, 1)), 6'($urandom)});
            end
            2: dwr(8'($urandom));
            3: do_op(0, 0, 8'h00, 0, dv, nv);
            4: do_op(0, 1, 8'h00, ($urandom_range(0, 3) == 0), dv, nv);
            5: ctrl(8'($urandom));
            default: pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 5'($urandom));
         endcase
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vdp_port_ctrl.md
Name: vdp_port_ctrl

Overview:
- CPU-facing controller for the TMS9918-style video block.
- Decodes the two I/O ports (data 0x98, control 0x99) and sequences every CPU access to the VRAM CPU-side port: address latch, auto-increment and read-ahead buffer.
- Holds VDP registers R0–R7 and drives all video configuration outputs.
- Maintains the status register and the interrupt line.

Parameters:
- ADDR_W, 14, VRAM address width; address counter wraps modulo 2^ADDR_W.
- NREGS, 8, number of write-only control registers.

Ports:
- clk  in  1  system clock (the only clock).
- reset  in  1  asynchronous, active-high.
- io_wr  in  1  one-cycle CPU write strobe.
- io_rd  in  1  one-cycle CPU read strobe.
- io_a0  in  1  port select: 0 = data, 1 = control/status.
- io_din  in  8  CPU write data.
- io_dout  out  8  CPU read data; valid in the cycle of io_rd (combinational from held registers).
- busy  out  1  VRAM access in flight.
- vram_addr  out  14  VRAM CPU-side address.
- vram_wdata  out  8  VRAM write data.
- vram_we  out  1  VRAM write enable, one cycle.
- vram_re  out  1  VRAM read enable, one cycle.
- vram_rdata  in  8  VRAM read data; valid 1 cycle after vram_re.
- frame_tick  in  1  one-cycle pulse at the start of vertical retrace.
- coll_in  in  1  sprite collision from the renderer.
- fifth_in  in  1  too-many-sprites flag from the renderer.
- fifth_num  in  5  number of the fifth sprite.
- mode  out  2  0 = text, 1 = graphics I, 2 = graphics II, 3 = multicolor.
- video_on, sprite_large, sprite_enlarged, vert_retrace_int  out  1 each  R1 bits 6, 1, 0, 5.
- name_table_addr, color_table_addr, font_addr, sprite_attr_addr, sprite_pattern_table_addr  out  14 each  table bases.
- text_color, back_color  out  4 each  R7[7:4], R7[3:0].
- n_int  out  1  active-low interrupt.

Behaviour:
- Reset:
  - All registers, flags, the address counter and the read buffer are cleared; phase = 0; FSM = IDLE.
  - Resulting outputs: mode = 1, video_on = 0, n_int = 1, busy = 0, vram_we = 0, vram_re = 0.
  - Reset during an access aborts the access; the buffer stays 0.
- Control write:
  - Phase 0: latch io_din into the first-byte latch; phase goes to 1.
  - Phase 1, bit7 = 1: R[io_din[2:0]] <= latch.
  - Phase 1, bit7 = 0: addr <= {io_din[5:0], latch}. If bit6 = 0, also start a prefetch.
  - Phase 1 always returns phase to 0.
- Any data-port access or status read forces phase to 0.
- Data write: vram_we = 1 with vram_addr = addr and vram_wdata = io_din in the next cycle. Also buf <= io_din and addr <= addr + 1.
- Data read: io_dout = buf, then start a prefetch.
- Prefetch FSM, IDLE -> RD -> CAP -> IDLE:
  - RD: vram_re = 1, vram_addr = addr.
  - CAP: buf <= vram_rdata, addr <= addr + 1.
  - Latency from strobe to valid buf is 3 cycles.
  - busy = 1 in RD, CAP and the write cycle.
- Strobes arriving while busy = 1 are ignored. Callers space strobes at 4 or more cycles apart; the bench flags any violation.
- Address wraps 0x3FFF -> 0x0000.
- Table bases:
  - name = R2[3:0] << 10
  - color = R3 << 6
  - font = R4[2:0] << 11
  - sprite_attr = R5[6:0] << 7
  - sprite_pattern = R6[2:0] << 11
- Mode decode, in priority order: M1 (R1[4]) -> 0; M3 (R0[1]) -> 2; M2 (R1[3]) -> 3; none -> 1.
- Status word = {F, 5S, C, fifth_num_latched}.
  - frame_tick sets F.
  - coll_in sets C.
  - fifth_in sets 5S and latches fifth_num, only while 5S = 0.
- Status read: io_dout = status word; F, C and 5S clear at the end of the cycle.
  - If a set event coincides with the clearing read, the set wins: the flag reads 1 afterwards.
- n_int = ~(F & R1[5]). Enabling IE while F = 1 asserts n_int in the next cycle.

Decomposition:
- Package vdp_pkg holds:
  - mode encodings
  - register indices R0–R7
  - bit positions M1, M2, M3, BLANK, IE, SIZE, MAG
  - status bit positions
  - shift amounts for the table bases
- Sub-module vdp_status_reg (flags, fifth-sprite latch, clear-on-read, n_int) is natural. Everything else stays in vdp_port_ctrl.

Test Plan:
- Register write: control 0xE0 then 0x81 -> R1 = 0xE0; video_on = 1, vert_retrace_int = 1, mode = 1, phase = 0.
- Write address: control 0x00 then 0x58 -> addr = 0x1800. Data writes 0xAA, 0xBB -> vram_we at 0x1800 and 0x1801; addr = 0x1802.
- Read setup: control 0xFF then 0x3F -> vram_re at 0x3FFF; buf = mem[0x3FFF]; addr wraps to 0x0000.
- Data read: io_dout = prefetched byte; the next prefetch is from 0x0000.
- Interrupt: IE = 1, frame_tick -> n_int = 0. Status read returns bit7 = 1 and n_int = 1 in the next cycle. frame_tick coinciding with the status read -> F remains 1.
- Phase reset: control 0x12 then a status read, then control 0x34, 0x56 -> addr = 0x1634 (0x34 is taken as the first byte). Mode priority: R1[4] = 1 with R0[1] = 1 -> mode = 0.
